// File: rtl/bcd_display_scan_pkg.sv
// Shared constants for the multiplexed 4-digit seven-segment display scanner.
// Segment patterns are active-low, ordered {g,f,e,d,c,b,a}.
package bcd_disp_pkg;

   localparam int NUM_DIGITS = 4;

   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_DASH  = 7'h3F;

   // Entry n is the pattern for decimal digit n.
   localparam logic [9:0][6:0] SEG_TABLE = {
      7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
      7'h19, 7'h30, 7'h24, 7'h79, 7'h40
   };

   typedef enum logic [$clog2(NUM_DIGITS)-1:0] {
      DIG_ONES = 2'd0,
      DIG_TENS = 2'd1,
      DIG_HUND = 2'd2,
      DIG_THOU = 2'd3
   } digit_idx_t;

   function automatic digit_idx_t next_idx(input digit_idx_t cur);
      digit_idx_t nxt;
      unique case (cur)
         DIG_ONES: nxt = DIG_TENS;
         DIG_TENS: nxt = DIG_HUND;
         DIG_HUND: nxt = DIG_THOU;
         DIG_THOU: nxt = DIG_ONES;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/bcd_display_scan_if.sv
// Bundle of the BCD digit inputs and the display drive outputs.
// The scanner uses the slave side; the digit source / board model uses master.
interface bcd_display_scan_if;
   import bcd_disp_pkg::*;

   logic [3:0]            ones;
   logic [3:0]            tens;
   logic [3:0]            hundreds;
   logic [3:0]            thousands;
   logic                  blank_lz;
   logic [NUM_DIGITS-1:0] an;
   logic [6:0]            seg;
   logic                  dp;
   logic                  frame_tick;

   modport slave (
      input  ones, tens, hundreds, thousands, blank_lz,
      output an, seg, dp, frame_tick
   );

   modport master (
      output ones, tens, hundreds, thousands, blank_lz,
      input  an, seg, dp, frame_tick
   );

endinterface

// File: rtl/bcd_display_scan_seg7.sv
// Combinational BCD-to-seven-segment decoder; codes 10-15 render as a dash.
module seg7_decode
   import bcd_disp_pkg::*;
(
   input  logic [3:0] digit,
   input  logic       blank,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_DASH;
      if (blank) begin
         seg = SEG_BLANK;
      end else if (digit <= 4'd9) begin
         seg = SEG_TABLE[digit];
      end
   end

endmodule

// File: rtl/bcd_display_scan.sv
// Time-multiplexed driver for a 4-digit common-anode display with a per-frame
// snapshot of the BCD inputs and optional leading-zero blanking.
module bcd_display_scan
   import bcd_disp_pkg::*;
#(
   parameter int REFRESH_DIV = 50000
) (
   input  logic               clk,
   input  logic               rst,
   bcd_display_scan_if.slave  bus
);

   localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);

   logic [PW-1:0]           presc_q, presc_d;
   digit_idx_t              idx_q, idx_d;
   logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
   logic [NUM_DIGITS-1:0]   an_q, an_d;
   logic [6:0]              seg_q, seg_d;
   logic                    frame_q, frame_d;

   logic       slot_tick;
   logic       frame_wrap;
   logic [3:0] cur_digit;
   logic       blank_cur;
   logic       lz_thou, lz_hund, lz_tens;

   assign slot_tick  = (presc_q == PRESC_LAST);
   assign frame_wrap = slot_tick && (idx_q == DIG_THOU);

   // A digit is a leading zero only if every more-significant digit is too.
   assign lz_thou = (shadow_q[15:12] == 4'd0);
   assign lz_hund = lz_thou && (shadow_q[11:8] == 4'd0);
   assign lz_tens = lz_hund && (shadow_q[7:4] == 4'd0);

   always_comb begin
      presc_d   = slot_tick ? '0 : presc_q + 1'b1;
      idx_d     = slot_tick ? next_idx(idx_q) : idx_q;
      shadow_d  = frame_wrap ? {bus.thousands, bus.hundreds, bus.tens, bus.ones}
                             : shadow_q;
      frame_d   = frame_wrap;
      cur_digit = shadow_q[3:0];
      blank_cur = 1'b0;
      unique case (idx_q)
         DIG_ONES: begin
            cur_digit = shadow_q[3:0];
            blank_cur = 1'b0;
         end
         DIG_TENS: begin
            cur_digit = shadow_q[7:4];
            blank_cur = bus.blank_lz && lz_tens;
         end
         DIG_HUND: begin
            cur_digit = shadow_q[11:8];
            blank_cur = bus.blank_lz && lz_hund;
         end
         DIG_THOU: begin
            cur_digit = shadow_q[15:12];
            blank_cur = bus.blank_lz && lz_thou;
         end
      endcase
      an_d = blank_cur ? '1 : ~(NUM_DIGITS'(1) << idx_q);
   end

   seg7_decode u_seg7_decode (
      .digit (cur_digit),
      .blank (blank_cur),
      .seg   (seg_d)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         presc_q  <= '0;
         idx_q    <= DIG_ONES;
         shadow_q <= '0;
         an_q     <= '1;
         seg_q    <= SEG_BLANK;
         frame_q  <= 1'b0;
      end else begin
         presc_q  <= presc_d;
         idx_q    <= idx_d;
         shadow_q <= shadow_d;
         an_q     <= an_d;
         seg_q    <= seg_d;
         frame_q  <= frame_d;
      end
   end

   assign bus.an         = an_q;
   assign bus.seg        = seg_q;
   assign bus.dp         = 1'b1;
   assign bus.frame_tick = frame_q;

endmodule

// File: tb/tb_bcd_display_scan.sv
// Directed bench for bcd_display_scan with a 4-clock digit slot (16-clock frame).
module tb_bcd_display_scan;
   import bcd_disp_pkg::*;

   logic clk;
   logic rst;
   int   checks;
   int   failures;

   bcd_display_scan_if bus ();

   bcd_display_scan #(.REFRESH_DIV(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic set_digits(input logic [3:0] th, input logic [3:0] hu,
                             input logic [3:0] te, input logic [3:0] on,
                             input logic blz);
      bus.thousands = th;
      bus.hundreds  = hu;
      bus.tens      = te;
      bus.ones      = on;
      bus.blank_lz  = blz;
   endtask

   // Samples 4 negedges per slot; slot 0 starts one clock after a frame_tick
   // sample (or after reset release), and frame_tick is due on the last one.
   task automatic check_slots(input int first, input int last,
                              input logic [3:0][3:0] ean,
                              input logic [3:0][6:0] eseg,
                              input string nm);
      logic exp_ft;
      for (int k = first; k <= last; k++) begin
         for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            exp_ft = (k == 3 && c == 3);
            checks++;
            if (bus.an !== ean[k]) begin
               failures++;
               $display("FAIL %s_an slot=%0d cyc=%0d got=%h exp=%h", nm, k, c, bus.an, ean[k]);
            end
            checks++;
            if (bus.seg !== eseg[k]) begin
               failures++;
               $display("FAIL %s_seg slot=%0d cyc=%0d got=%h exp=%h", nm, k, c, bus.seg, eseg[k]);
            end
            checks++;
            if (bus.frame_tick !== exp_ft) begin
               failures++;
               $display("FAIL %s_frame_tick slot=%0d cyc=%0d got=%b exp=%b", nm, k, c, bus.frame_tick, exp_ft);
            end
            checks++;
            if (bus.dp !== 1'b1) begin
               failures++;
               $display("FAIL %s_dp got=%b exp=1", nm, bus.dp);
            end
         end
      end
   endtask

   task automatic wait_frame(input string nm);
      int n;
      n = 0;
      @(negedge clk);
      while (bus.frame_tick !== 1'b1 && n < 64) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (bus.frame_tick !== 1'b1) begin
         failures++;
         $display("FAIL %s_wait_frame got=%b exp=1 after %0d cycles", nm, bus.frame_tick, n);
      end
   endtask

   task automatic check_reset_outputs(input string nm);
      checks++;
      if (bus.an !== 4'hF) begin
         failures++;
         $display("FAIL %s_an got=%h exp=f", nm, bus.an);
      end
      checks++;
      if (bus.seg !== 7'h7F) begin
         failures++;
         $display("FAIL %s_seg got=%h exp=7f", nm, bus.seg);
      end
      checks++;
      if (bus.dp !== 1'b1) begin
         failures++;
         $display("FAIL %s_dp got=%b exp=1", nm, bus.dp);
      end
      checks++;
      if (bus.frame_tick !== 1'b0) begin
         failures++;
         $display("FAIL %s_frame_tick got=%b exp=0", nm, bus.frame_tick);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      set_digits(4'd1, 4'd2, 4'd3, 4'd4, 1'b0);
      repeat (3) @(negedge clk);
      check_reset_outputs("reset_hold");
      rst = 1'b0;
      // First frame after reset shows the cleared shadow; no tick before clock 16.
      check_slots(0, 3, {4'h7, 4'hB, 4'hD, 4'hE},
                  {7'h40, 7'h40, 7'h40, 7'h40}, "post_reset");
   endtask

   task automatic test_scan();
      check_slots(0, 3, {4'h7, 4'hB, 4'hD, 4'hE},
                  {7'h79, 7'h24, 7'h30, 7'h19}, "scan_1234_a");
      check_slots(0, 3, {4'h7, 4'hB, 4'hD, 4'hE},
                  {7'h79, 7'h24, 7'h30, 7'h19}, "scan_1234_b");
   endtask

   task automatic test_blanking();
      set_digits(4'd0, 4'd0, 4'd4, 4'd2, 1'b1);
      wait_frame("blank_0042");
      check_slots(0, 3, {4'hF, 4'hF, 4'hD, 4'hE},
                  {7'h7F, 7'h7F, 7'h19, 7'h24}, "blank_0042");
      set_digits(4'd0, 4'd0, 4'd0, 4'd0, 1'b1);
      wait_frame("blank_0000");
      check_slots(0, 3, {4'hF, 4'hF, 4'hF, 4'hE},
                  {7'h7F, 7'h7F, 7'h7F, 7'h40}, "blank_0000");
      set_digits(4'd1, 4'd0, 4'd0, 4'd5, 1'b1);
      wait_frame("blank_1005");
      check_slots(0, 3, {4'h7, 4'hB, 4'hD, 4'hE},
                  {7'h79, 7'h40, 7'h40, 7'h12}, "blank_1005");
      set_digits(4'd0, 4'd1, 4'd0, 4'd5, 1'b1);
      wait_frame("blank_0105");
      check_slots(0, 3, {4'hF, 4'hB, 4'hD, 4'hE},
                  {7'h7F, 7'h79, 7'h40, 7'h12}, "blank_0105");
   endtask

   task automatic test_blank_live();
      // blank_lz takes effect on the very next slot, without a new snapshot.
      bus.blank_lz = 1'b0;
      check_slots(0, 3, {4'h7, 4'hB, 4'hD, 4'hE},
                  {7'h40, 7'h79, 7'h40, 7'h12}, "blank_live");
   endtask

   task automatic test_invalid();
      set_digits(4'd0, 4'd0, 4'hC, 4'd9, 1'b1);
      wait_frame("invalid");
      check_slots(0, 3, {4'hF, 4'hF, 4'hD, 4'hE},
                  {7'h7F, 7'h7F, 7'h3F, 7'h10}, "invalid");
   endtask

   task automatic test_snapshot();
      set_digits(4'd1, 4'd2, 4'd3, 4'd4, 1'b0);
      wait_frame("snap_load");
      check_slots(0, 1, {4'h7, 4'hB, 4'hD, 4'hE},
                  {7'h79, 7'h24, 7'h30, 7'h19}, "snap_old_a");
      set_digits(4'd5, 4'd6, 4'd7, 4'd8, 1'b0);
      check_slots(2, 3, {4'h7, 4'hB, 4'hD, 4'hE},
                  {7'h79, 7'h24, 7'h30, 7'h19}, "snap_old_b");
      check_slots(0, 3, {4'h7, 4'hB, 4'hD, 4'hE},
                  {7'h12, 7'h02, 7'h78, 7'h00}, "snap_new");
   endtask

   task automatic test_async_reset();
      check_slots(0, 1, {4'h7, 4'hB, 4'hD, 4'hE},
                  {7'h12, 7'h02, 7'h78, 7'h00}, "async_pre");
      @(negedge clk);
      #2 rst = 1'b1;
      #1 check_reset_outputs("async_assert");
      @(negedge clk);
      check_reset_outputs("async_hold");
      rst = 1'b0;
      check_slots(0, 3, {4'h7, 4'hB, 4'hD, 4'hE},
                  {7'h40, 7'h40, 7'h40, 7'h40}, "async_restart");
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst      = 1'b1;
      set_digits(4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
      test_reset();
      test_scan();
      test_blanking();
      test_blank_live();
      test_invalid();
      test_snapshot();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/bcd_display_scan.md
BCD_DISPLAY_SCAN -- requirements
Module: bcd_display_scan

Interface
REQ-001 The block SHALL have parameter REFRESH_DIV, default 50000, giving clocks per digit slot (legal range >= 2).
REQ-002 The block SHALL have port clk, input, 1, the single system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, reset, asynchronous and active-high.
REQ-004 The block SHALL have ports ones, tens, hundreds, thousands, input, 4 each, the BCD digits from the upstream binary-to-BCD converter.
REQ-005 The block SHALL have port blank_lz, input, 1, leading-zero blanking enable.
REQ-006 The block SHALL have port an, output, 4, digit anodes, active-low; an[0]=ones ... an[3]=thousands.
REQ-007 The block SHALL have port seg, output, 7, segments active-low, ordered {g,f,e,d,c,b,a}.
REQ-008 The block SHALL have port dp, output, 1, decimal point, active-low, constant 1 (off).
REQ-009 The block SHALL have port frame_tick, output, 1, a one-cycle pulse at each frame start.

Function
REQ-010 Prescaler SHALL count 0..REFRESH_DIV-1 and wrap to 0; the wrap cycle is the slot tick.
REQ-011 On each slot tick the digit index SHALL advance 0->1->2->3->0, where 0=ones.
REQ-012 A 16-bit shadow register SHALL capture {thousands,hundreds,tens,ones} on the slot tick where the index goes 3->0; inputs are ignored at all other times (no mid-frame tearing).
REQ-013 frame_tick SHALL be registered and high for exactly the first clock in which the index equals 0 after a 3->0 advance.
REQ-014 an and seg SHALL be registered outputs derived from the current index and the shadow register, changing one clock after the index changes.
REQ-015 Only the anode bit of the current index SHALL be 0; all other anode bits SHALL be 1.
REQ-016 Segment encoding (hex, {g..a}) SHALL be: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10.
REQ-017 A digit value of 10-15 SHALL display a dash (seg=3F) and SHALL count as nonzero for blanking.
REQ-018 With blank_lz=1, the following SHALL be blanked:
- thousands, if its shadow value is 0;
- hundreds, if thousands and hundreds are 0;
- tens, if thousands, hundreds and tens are 0;
- ones, never.
REQ-019 A blanked slot SHALL drive seg=7F and all anodes = 1 for its whole duration.
REQ-020 blank_lz SHALL be sampled live each clock (not shadowed).
REQ-021 Blanking SHALL use the shadowed digits.

Reset
REQ-022 While rst=1, outputs SHALL be: an=F, seg=7F, dp=1, frame_tick=0.
REQ-023 While rst=1, state SHALL be: prescaler=0, index=0, shadow=0.
REQ-024 Reset assertion mid-scan SHALL force REQ-022/023 values immediately, without waiting for a clock edge.
REQ-025 On the first clock after rst deasserts, the block SHALL drive an=E and seg=40 (shadow ones=0).
REQ-026 No frame_tick SHALL be generated until the first 3->0 advance after reset.

Structure
REQ-027 Package bcd_disp_pkg SHALL hold:
- segment constants SEG_BLANK=7F and SEG_DASH=3F;
- the 0-9 encoding table;
- NUM_DIGITS=4.
REQ-028 The digit-to-segment mapping SHALL be a sub-module seg7_decode with inputs digit[3:0] and blank, output seg[6:0]; it is purely combinational.
REQ-029 The prescaler, index, shadow, blanking logic and output registers SHALL reside in bcd_display_scan.
REQ-030 Target size SHALL be roughly 150-250 lines of RTL.

Verification (REFRESH_DIV=4)
REQ-031 Reset: hold rst=1 -> an=F, seg=7F, dp=1; release -> next clock an=E, seg=40.
REQ-032 Scan: inputs thousands..ones=1,2,3,4, blank_lz=0, after one frame ->
- an cycles E,D,B,7, 4 clocks each;
- seg=19,30,24,79;
- frame_tick every 16 clocks.
REQ-033 Blanking: inputs 0,0,4,2 with blank_lz=1 -> thousands/hundreds slots show an=F, seg=7F; tens=19, ones=24. Inputs 0,0,0,0 -> only the ones slot shows 40.
REQ-034 Snapshot: change inputs from 1234 to 5678 in the middle of the frame -> displayed digits unchanged until after the next frame_tick, then 5678.
REQ-035 Invalid digit: tens=C with blank_lz=1 and upper digits 0 -> tens slot seg=3F, not blanked.
REQ-036 Async reset: assert rst between clock edges during index 2 -> an=F, seg=7F before the next edge; release -> scan restarts at ones.
